// File: rtl/simd_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and instruction-width helper for simd_sequencer.
// Defining SIMD_SEQ_STEP_EN adds the STEP_WAIT single-step state.
package simd_sequencer_pkg;

    localparam int OPCODE_WIDTH = 3;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 3'b000;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 3'b001;
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = 3'b010;
    localparam logic [OPCODE_WIDTH-1:0] OP_DOT   = 3'b011;
    localparam logic [OPCODE_WIDTH-1:0] OP_PASSB = 3'b100;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 3'b111;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE     = 3'd0;
    localparam seq_state_t ST_FETCH    = 3'd1;
    localparam seq_state_t ST_WAIT_MEM = 3'd2;
    localparam seq_state_t ST_ISSUE    = 3'd3;
    localparam seq_state_t ST_EXEC     = 3'd4;
    localparam seq_state_t ST_DONE     = 3'd5;
`ifdef SIMD_SEQ_STEP_EN
    localparam seq_state_t ST_STEP_WAIT = 3'd6;
`endif

    // Instruction layout: {opcode, A, B, R, flag}; the opcode occupies the top bits.
    function automatic int ins_width(input int addr_width);
        return OPCODE_WIDTH + 3 * addr_width + 1;
    endfunction

    function automatic logic is_illegal(input logic [OPCODE_WIDTH-1:0] op);
        return (op == 3'b101) || (op == 3'b110);
    endfunction

endpackage

// File: rtl/simd_sequencer_if.sv
// Control, instruction-memory and decoder-side signals of simd_sequencer.
// Defining SIMD_SEQ_STEP_EN adds the 'step' single-step input.
interface simd_sequencer_if #(
    parameter int PC_WIDTH  = 8,
    parameter int INS_WIDTH = 34
);
    // start is accepted only in the cycle the sequencer is idle and is otherwise
    // dropped; instr_valid and done are single-cycle pulses with no backpressure.
    logic                 start;
    logic [PC_WIDTH-1:0]  prog_len;
    logic                 imem_en;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic [INS_WIDTH-1:0] imem_rdata;
    logic [INS_WIDTH-1:0] instruction;
    logic                 instr_valid;
    logic                 busy;
    logic                 done;
    logic                 err;
`ifdef SIMD_SEQ_STEP_EN
    logic                 step;
`endif

    modport master (
`ifdef SIMD_SEQ_STEP_EN
        input  step,
`endif
        input  start, prog_len, imem_rdata,
        output imem_en, imem_addr, instruction, instr_valid, busy, done, err
    );

    modport slave (
`ifdef SIMD_SEQ_STEP_EN
        output step,
`endif
        output start, prog_len, imem_rdata,
        input  imem_en, imem_addr, instruction, instr_valid, busy, done, err
    );

endinterface

// File: rtl/simd_sequencer_seq_lat_counter.sv
// Execution latency down-counter: loaded at issue, o_expire marks the final EXEC cycle.
module seq_lat_counter #(
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    output logic                 o_expire
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    assign o_expire = (r_cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/simd_sequencer.sv
// Program sequencer: fetches, issues and times instructions for the SIMD datapath.
// Optional macro SIMD_SEQ_STEP_EN inserts a STEP_WAIT stall between instructions.
module simd_sequencer
    import simd_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int PC_WIDTH    = 8,
    parameter int PE_LATENCY  = 2,
    parameter int DOT_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    simd_sequencer_if.master bus,
    output seq_state_t       o_dbg_state
);

    localparam int INS_WIDTH = ins_width(ADDR_WIDTH);
    localparam int MAX_LAT   = (DOT_LATENCY > PE_LATENCY) ? DOT_LATENCY : PE_LATENCY;
    localparam int CNT_WIDTH = $clog2(MAX_LAT + 1);

    seq_state_t           r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  r_prog_len;
    logic [INS_WIDTH-1:0] r_instruction;
    logic                 r_err;

    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [PC_WIDTH-1:0]     w_pc_next;
    logic                    w_last;
    logic                    w_exec_op;
    logic                    w_issue;
    logic                    w_expire;
    logic [CNT_WIDTH-1:0]    w_load_val;

    assign w_opcode   = r_instruction[INS_WIDTH-1 -: OPCODE_WIDTH];
    assign w_pc_next  = r_pc + PC_WIDTH'(1);
    assign w_last     = (w_pc_next == r_prog_len);
    // Opcodes 000..100 reach the datapath; HALT and the two illegal codes do not.
    assign w_exec_op  = (w_opcode != OP_HALT) && !is_illegal(w_opcode);
    assign w_issue    = (r_state == ST_ISSUE) && w_exec_op;
    assign w_load_val = (w_opcode == OP_DOT) ? CNT_WIDTH'(DOT_LATENCY) : CNT_WIDTH'(PE_LATENCY);

    seq_lat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_issue),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_prog_len    <= '0;
            r_instruction <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_prog_len <= bus.prog_len;
                        r_pc       <= '0;
                        r_err      <= 1'b0;
                        r_state    <= (bus.prog_len == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT_MEM;
                end
                ST_WAIT_MEM: begin
                    r_instruction <= bus.imem_rdata;
                    r_state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (w_opcode == OP_HALT) begin
                        r_state <= ST_DONE;
                    end else if (is_illegal(w_opcode)) begin
                        r_err   <= 1'b1;
                        r_pc    <= w_pc_next;
                        r_state <= w_last ? ST_DONE : ST_FETCH;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_expire) begin
                        r_pc <= w_pc_next;
`ifdef SIMD_SEQ_STEP_EN
                        r_state <= w_last ? ST_DONE : ST_STEP_WAIT;
`else
                        r_state <= w_last ? ST_DONE : ST_FETCH;
`endif
                    end
                end
`ifdef SIMD_SEQ_STEP_EN
                ST_STEP_WAIT: begin
                    if (bus.step) begin
                        r_state <= ST_FETCH;
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so they follow it with no extra cycle.
    assign bus.imem_en     = (r_state == ST_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instruction = r_instruction;
    assign bus.instr_valid = w_issue;
    assign bus.busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.err         = r_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_simd_sequencer.sv
// Randomized and directed bench for simd_sequencer against a program-level timing model.
module tb_simd_sequencer;
    import simd_sequencer_pkg::*;

    localparam int ADDR_WIDTH = 10;
    localparam int PC_WIDTH   = 8;
    localparam int PE_LAT     = 2;
    localparam int DOT_LAT    = 4;
    localparam int INS_W      = OPCODE_WIDTH + 3 * ADDR_WIDTH + 1;
    localparam int BUDGET     = 2000;
`ifdef SIMD_SEQ_STEP_EN
    localparam int STEP_EXTRA = 1;
`else
    localparam int STEP_EXTRA = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       step_drv;
    seq_state_t dbg_state;
    int         cyc = 0;

    simd_sequencer_if #(.PC_WIDTH(PC_WIDTH), .INS_WIDTH(INS_W)) bus ();

    simd_sequencer #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .PC_WIDTH    (PC_WIDTH),
        .PE_LATENCY  (PE_LAT),
        .DOT_LATENCY (DOT_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

`ifdef SIMD_SEQ_STEP_EN
    assign bus.step = step_drv;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction BRAM: one-cycle registered read.
    logic [INS_W-1:0] imem [256];
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= imem[bus.imem_addr];

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int               t0;
    int               mt;
    bit               mon_en = 1'b0;
    bit               done_seen;
    int               done_t, done_cnt, busy_cnt;
    logic             err_t1;
    int               obs_fetch_t[$];
    logic [PC_WIDTH-1:0] obs_fetch_a[$];
    int               obs_valid_t[$];
    logic [INS_W-1:0] obs_valid_i[$];

    always @(negedge clk) begin
        if (mon_en) begin
            mt = cyc - t0;
            if (bus.imem_en) begin
                obs_fetch_t.push_back(mt);
                obs_fetch_a.push_back(bus.imem_addr);
            end
            if (bus.instr_valid) begin
                obs_valid_t.push_back(mt);
                obs_valid_i.push_back(bus.instruction);
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (!done_seen) done_t = mt;
                done_seen = 1'b1;
            end
            if (mt == 1) err_t1 = bus.err;
        end
    end

    task automatic clear_obs();
        obs_fetch_t.delete(); obs_fetch_a.delete();
        obs_valid_t.delete(); obs_valid_i.delete();
        done_seen = 1'b0; done_t = -1; done_cnt = 0; busy_cnt = 0; err_t1 = 1'bx;
    endtask

    // ---------------- reference model ----------------
    int               exp_fetch_t[$];
    logic [PC_WIDTH-1:0] exp_fetch_a[$];
    int               exp_valid_t[$];
    logic [INS_W-1:0] exp_q[$];
    int               exp_done;
    int               exp_pc;
    logic             exp_err;

    // Walks the program: fetch at t, issue at t+2, then 3+latency cycles per executed op.
    task automatic build_model(input int len);
        int t;
        int pc;
        logic [2:0] op;
        exp_fetch_t.delete(); exp_fetch_a.delete();
        exp_valid_t.delete(); exp_q.delete();
        exp_err = 1'b0;
        exp_done = (len == 0) ? 1 : -1;
        t = 1;
        pc = 0;
        while (exp_done < 0) begin
            op = imem[pc][INS_W-1 -: 3];
            exp_fetch_t.push_back(t);
            exp_fetch_a.push_back(PC_WIDTH'(pc));
            if (op == OP_HALT) begin
                exp_done = t + 3;
            end else if (op == 3'b101 || op == 3'b110) begin
                exp_err = 1'b1;
                pc++;
                t += 3;
                if (pc == len) exp_done = t;
            end else begin
                exp_valid_t.push_back(t + 2);
                exp_q.push_back(imem[pc]);
                pc++;
                t += 3 + ((op == OP_DOT) ? DOT_LAT : PE_LAT);
                if (pc == len) exp_done = t;
                else t += STEP_EXTRA;
            end
        end
        exp_pc = pc;
    endtask

    // ---------------- driver ----------------
    function automatic logic [INS_W-1:0] mk_ins(input logic [2:0] op);
        logic [INS_W-4:0] rest;
        rest = (INS_W-3)'({$urandom, $urandom});
        return {op, rest};
    endfunction

    // Runs one program; intrude>0 pulses start again at that cycle to prove it is ignored.
    task automatic run_program(input string name, input int len, input int intrude);
        int k;
        build_model(len);
        clear_obs();
        @(negedge clk);
        t0 = cyc;
        mon_en = 1'b1;
        bus.start = 1'b1;
        bus.prog_len = PC_WIDTH'(len);
        @(negedge clk);
        bus.start = 1'b0;
        bus.prog_len = PC_WIDTH'($urandom);
        #1;
        k = 0;
        while (!done_seen && k < BUDGET) begin
            @(negedge clk);
            #1;
            bus.start = (intrude > 0) && (cyc - t0 == intrude);
            k++;
        end
        check_eq({name, ".finished"}, done_seen, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        mon_en = 1'b0;
        check_eq({name, ".n_fetch"}, obs_fetch_t.size(), exp_fetch_t.size());
        for (int i = 0; i < obs_fetch_t.size() && i < exp_fetch_t.size(); i++) begin
            check_eq($sformatf("%s.fetch_t[%0d]", name, i), obs_fetch_t[i], exp_fetch_t[i]);
            check_eq($sformatf("%s.fetch_a[%0d]", name, i), obs_fetch_a[i], exp_fetch_a[i]);
        end
        check_eq({name, ".n_valid"}, obs_valid_t.size(), exp_valid_t.size());
        for (int i = 0; i < obs_valid_t.size() && i < exp_valid_t.size(); i++) begin
            check_eq($sformatf("%s.valid_t[%0d]", name, i), obs_valid_t[i], exp_valid_t[i]);
            check_eq($sformatf("%s.valid_i[%0d]", name, i), obs_valid_i[i], exp_q[i]);
        end
        check_eq({name, ".done_t"}, done_t, exp_done);
        check_eq({name, ".done_cnt"}, done_cnt, 1);
        check_eq({name, ".busy_cycles"}, busy_cnt, exp_done - 1);
        check_eq({name, ".err_cleared"}, err_t1, 1'b0);
        check_eq({name, ".err_final"}, bus.err, exp_err);
        check_eq({name, ".pc_final"}, bus.imem_addr, PC_WIDTH'(exp_pc));
        check_eq({name, ".idle"}, dbg_state, ST_IDLE);
    endtask

    task automatic check_quiet(input string name);
        check_eq({name, ".imem_en"}, bus.imem_en, 1'b0);
        check_eq({name, ".instr_valid"}, bus.instr_valid, 1'b0);
        check_eq({name, ".busy"}, bus.busy, 1'b0);
        check_eq({name, ".done"}, bus.done, 1'b0);
        check_eq({name, ".err"}, bus.err, 1'b0);
        check_eq({name, ".instruction"}, bus.instruction, '0);
        check_eq({name, ".imem_addr"}, bus.imem_addr, '0);
        check_eq({name, ".state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len, intrude, r, k;
        logic [2:0] op;
        rst = 1'b1;
        step_drv = 1'b1;
        bus.start = 1'b0;
        bus.prog_len = '0;
        for (int i = 0; i < 256; i++) imem[i] = mk_ins(3'($urandom_range(0, 4)));

        // Reset holds the sequencer idle even with start asserted.
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.prog_len = 8'd3;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_quiet("reset");
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("post_reset");

        // Two ADDs: issues at 3 and 8, done at 11.
        imem[0] = mk_ins(OP_ADD);
        imem[1] = mk_ins(OP_ADD);
        run_program("two_add", 2, 0);
        check_eq("two_add.done_abs", done_t, 11 + 2 * STEP_EXTRA / 2);

        // MUL, DOT, ADD: DOT stretches its EXEC to DOT_LAT cycles.
        imem[0] = mk_ins(OP_MUL);
        imem[1] = mk_ins(OP_DOT);
        imem[2] = mk_ins(OP_ADD);
        run_program("mul_dot_add", 3, 0);

        // HALT at pc 1 ends a 5-long program early.
        imem[0] = mk_ins(OP_SUB);
        imem[1] = mk_ins(OP_HALT);
        run_program("halt", 5, 0);
        check_eq("halt.pc_abs", bus.imem_addr, 8'd1);

        // Illegal opcode sets sticky err and is skipped.
        imem[0] = mk_ins(3'b110);
        imem[1] = mk_ins(OP_PASSB);
        run_program("illegal", 2, 0);
        check_eq("illegal.err_abs", bus.err, 1'b1);

        // Empty program finishes at cycle 1 and clears the previous err.
        run_program("empty", 0, 0);
        check_eq("empty.done_abs", done_t, 1);

        // Randomized programs, some with a stray start during the run.
        for (int n = 0; n < 25; n++) begin
            len = $urandom_range(0, 8);
            for (int i = 0; i < 10; i++) begin
                r = $urandom_range(0, 15);
                if (r < 10)      op = 3'($urandom_range(0, 4));
                else if (r < 12) op = (r == 10) ? 3'b101 : 3'b110;
                else if (r == 12) op = OP_HALT;
                else             op = OP_DOT;
                imem[i] = mk_ins(op);
            end
            build_model(len);
            intrude = ($urandom_range(0, 1) == 1 && exp_done >= 2) ? $urandom_range(2, exp_done) : 0;
            run_program($sformatf("rand%0d", n), len, intrude);
        end

        // Reset during EXEC aborts without a done pulse.
        imem[0] = mk_ins(OP_ADD);
        imem[1] = mk_ins(OP_ADD);
        imem[2] = mk_ins(OP_ADD);
        clear_obs();
        @(negedge clk);
        t0 = cyc;
        mon_en = 1'b1;
        bus.start = 1'b1;
        bus.prog_len = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (dbg_state != ST_EXEC && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_exec.reached", dbg_state, ST_EXEC);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_exec.state", dbg_state, ST_IDLE);
        check_eq("rst_exec.busy", bus.busy, 1'b0);
        check_eq("rst_exec.pc", bus.imem_addr, '0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check_eq("rst_exec.no_done", done_cnt, 0);
        mon_en = 1'b0;

`ifdef SIMD_SEQ_STEP_EN
        // Single-step: step low stalls after the first instruction.
        step_drv = 1'b0;
        clear_obs();
        @(negedge clk);
        t0 = cyc;
        mon_en = 1'b1;
        bus.start = 1'b1;
        bus.prog_len = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check_eq("step.stalled", dbg_state, ST_STEP_WAIT);
        check_eq("step.n_fetch", obs_fetch_t.size(), 1);
        step_drv = 1'b1;
        k = 0;
        while (!done_seen && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("step.done", done_seen, 1'b1);
        check_eq("step.n_fetch2", obs_fetch_t.size(), 2);
        mon_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
